nn_layer_sequencer: RTL and testbench

- Sequences the 2-layer MLP datapath: 784 inputs -> 200 hidden -> 10 outputs, 64 lanes wide.
- Drives the input/output SRAM, weight SRAM 1/2 and intermediate SRAM addresses.
- Accumulates the 64-lane MAC partial sums per neuron.
- Writes activated hidden results into the intermediate SRAM and emits the 10 raw output sums.

---
 rtl/nn_layer_sequencer_if.sv | 31 +++
 rtl/nn_layer_sequencer.sv | 167 ++++++++++++++++
 tb/tb_nn_layer_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_layer_sequencer_if.sv
// Control/data bundle between the MLP layer sequencer and its SRAM/MAC datapath.
// The master side is the sequencer. The slave side is the datapath or testbench.
interface nn_layer_sequencer_if #(
  parameter int unsigned LANES = 64
);
  logic               start;
  logic signed [15:0] psum;
  logic               busy;
  logic               done;
  logic [3:0]         in_addr;
  logic [11:0]        w_addr;
  logic               w_sel;
  logic [LANES-1:0]   lane_en;
  logic [1:0]         mid_addr;
  logic [LANES-1:0]   mid_we;
  logic signed [15:0] sum;
  logic               out_valid;
  logic [3:0]         out_idx;

  modport master (
    input  start, psum,
    output busy, done, in_addr, w_addr, w_sel, lane_en,
           mid_addr, mid_we, sum, out_valid, out_idx
  );

  modport slave (
    output start, psum,
    input  busy, done, in_addr, w_addr, w_sel, lane_en,
           mid_addr, mid_we, sum, out_valid, out_idx
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Two-layer MLP sequencer: walks neurons and chunks, issues SRAM/MAC addresses,
// and accumulates saturating 16-bit partial sums per neuron.
module nn_layer_sequencer #(
  parameter int unsigned LANES  = 64,
  parameter int unsigned N_IN   = 784,
  parameter int unsigned N_HID  = 200,
  parameter int unsigned N_OUT  = 10,
  parameter int unsigned RD_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  nn_layer_sequencer_if.master bus
);

  localparam int unsigned CH1 = (N_IN + LANES - 1) / LANES;
  localparam int unsigned CH2 = (N_HID + LANES - 1) / LANES;
  localparam int unsigned T1  = N_IN - (CH1 - 1) * LANES;
  localparam int unsigned T2  = N_HID - (CH2 - 1) * LANES;
  localparam int unsigned NW  = $clog2(N_HID);
  localparam int unsigned CW  = $clog2(CH1);
  localparam int unsigned DW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [LANES-1:0] MASK1   = {LANES{1'b1}} >> (LANES - T1);
  localparam logic [LANES-1:0] MASK2   = {LANES{1'b1}} >> (LANES - T2);
  localparam logic [CW-1:0]    C1_LAST = CW'(CH1 - 1);
  localparam logic [CW-1:0]    C2_LAST = CW'(CH2 - 1);
  localparam logic [NW-1:0]    H_LAST  = NW'(N_HID - 1);
  localparam logic [NW-1:0]    O_LAST  = NW'(N_OUT - 1);
  localparam logic [DW-1:0]    D_LAST  = DW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, L1_RD, L1_DRAIN, L1_WB, L2_RD, L2_DRAIN, L2_WB, DONE
  } state_t;

  state_t             state, state_nx;
  logic [NW-1:0]      n, n_nx;
  logic [CW-1:0]      c, c_nx;
  logic [DW-1:0]      dcnt, dcnt_nx;
  logic [RD_LAT-1:0]  vpipe;
  logic               rd_issue;
  logic signed [15:0] acc;

  function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic [16:0] s;
    s = {a[15], a} + {b[15], b};
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7FFF;
    return s[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n     <= '0;
      c     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      n     <= n_nx;
      c     <= c_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // vpipe[RD_LAT-1] marks that psum belongs to a chunk issued RD_LAT cycles ago
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe <= '0;
      acc   <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(rd_issue);
      if (state == IDLE || state == L1_WB || state == L2_WB) acc <= '0;
      else if (vpipe[RD_LAT-1]) acc <= sat_add(acc, bus.psum);
    end
  end

  assign bus.sum = acc;

  always_comb begin
    state_nx      = state;
    n_nx          = n;
    c_nx          = c;
    dcnt_nx       = dcnt;
    rd_issue      = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.in_addr   = '0;
    bus.w_addr    = '0;
    bus.w_sel     = 1'b0;
    bus.lane_en   = '0;
    bus.mid_addr  = '0;
    bus.mid_we    = '0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = L1_RD;
          n_nx     = '0;
          c_nx     = '0;
        end
      end
      L1_RD: begin
        rd_issue    = 1'b1;
        bus.in_addr = 4'(c);
        bus.w_addr  = 12'(32'(n) * CH1 + 32'(c));
        bus.lane_en = (c == C1_LAST) ? MASK1 : '1;
        if (c == C1_LAST) begin
          state_nx = L1_DRAIN;
          c_nx     = '0;
          dcnt_nx  = '0;
        end else begin
          c_nx = c + CW'(1);
        end
      end
      L1_DRAIN: begin
        if (dcnt == D_LAST) state_nx = L1_WB;
        else dcnt_nx = dcnt + DW'(1);
      end
      L1_WB: begin
        bus.mid_we   = LANES'(1) << (32'(n) % LANES);
        bus.mid_addr = 2'(32'(n) / LANES);
        if (n == H_LAST) begin
          state_nx = L2_RD;
          n_nx     = '0;
        end else begin
          state_nx = L1_RD;
          n_nx     = n + NW'(1);
        end
      end
      L2_RD: begin
        rd_issue     = 1'b1;
        bus.mid_addr = 2'(c);
        bus.w_addr   = 12'(32'(n) * CH2 + 32'(c));
        bus.w_sel    = 1'b1;
        bus.lane_en  = (c == C2_LAST) ? MASK2 : '1;
        if (c == C2_LAST) begin
          state_nx = L2_DRAIN;
          c_nx     = '0;
          dcnt_nx  = '0;
        end else begin
          c_nx = c + CW'(1);
        end
      end
      L2_DRAIN: begin
        if (dcnt == D_LAST) state_nx = L2_WB;
        else dcnt_nx = dcnt + DW'(1);
      end
      L2_WB: begin
        bus.out_valid = 1'b1;
        bus.out_idx   = 4'(n);
        if (n == O_LAST) begin
          state_nx = DONE;
        end else begin
          state_nx = L2_RD;
          n_nx     = n + NW'(1);
        end
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer: addressing, accumulation, saturation,
// timing and reset behaviour against hand-computed values.
module tb_nn_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  logic alt_mode = 1'b0;
  logic prev_rd  = 1'b0;
  logic [3:0] prev_c = '0;

  nn_layer_sequencer_if #(.LANES(64)) bus ();

  nn_layer_sequencer #(
    .LANES(64), .N_IN(784), .N_HID(200), .N_OUT(10), .RD_LAT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle. In alt_mode the bench acts as a 1-cycle-latency SRAM+MAC:
  // chunk c returns +0x7000 when even and -0x7000 when odd.
  task automatic tick();
    @(posedge clk);
    #1;
    if (alt_mode)
      bus.psum = prev_rd ? (prev_c[0] ? 16'sh9000 : 16'sh7000) : 16'sh0000;
    prev_rd = (bus.lane_en != '0) && !bus.w_sel;
    prev_c  = bus.in_addr;
  endtask

  // Leaves the bench in cycle 1, the first L1_RD cycle.
  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.lane_en !== 64'h0 || bus.sum !== 16'h0) begin
      fails++;
      $display("FAIL reset_init: busy=%b done=%b lane_en=%h sum=%h, required all 0",
               bus.busy, bus.done, bus.lane_en, bus.sum);
    end
    bus.psum = 16'sd1;
    start_pulse();
    for (int i = 0; i < 40; i++) tick();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.lane_en !== 64'h0 || bus.w_addr !== 12'h0 ||
        bus.in_addr !== 4'h0 || bus.sum !== 16'h0 || bus.mid_we !== 64'h0 ||
        bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL reset_midop: busy=%b lane_en=%h w_addr=%h in_addr=%h sum=%h, required all 0",
               bus.busy, bus.lane_en, bus.w_addr, bus.in_addr, bus.sum);
    end
    tick();
    rst = 1'b1;
    begin
      int busy_seen;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
        tick();
        if (bus.busy !== 1'b0) busy_seen++;
      end
      checks++;
      if (busy_seen != 0) begin
        fails++;
        $display("FAIL reset_idle100: busy high in %0d cycles, required 0", busy_seen);
      end
    end
  endtask

  task automatic test_accumulate();
    int pulses;
    pulses = 0;
    bus.psum = 16'sd1;
    start_pulse();
    for (int cyc = 1; cyc <= 3061; cyc++) begin
      if (cyc == 15) begin
        checks++;
        if (bus.sum !== 16'd13 || bus.mid_we !== 64'h1 || bus.mid_addr !== 2'd0) begin
          fails++;
          $display("FAIL wb_n0: sum=%0d mid_we=%h mid_addr=%0d, required 13 / 1 / 0",
                   bus.sum, bus.mid_we, bus.mid_addr);
        end
      end
      if (cyc == 990) begin
        checks++;
        if (bus.sum !== 16'd13 || bus.mid_we !== 64'h2 || bus.mid_addr !== 2'd1) begin
          fails++;
          $display("FAIL wb_n65: sum=%0d mid_we=%h mid_addr=%0d, required 13 / 2 / 1",
                   bus.sum, bus.mid_we, bus.mid_addr);
        end
      end
      if (cyc == 3000) begin
        checks++;
        if (bus.sum !== 16'd13 || bus.mid_we !== 64'h80 || bus.mid_addr !== 2'd3) begin
          fails++;
          $display("FAIL wb_n199: sum=%0d mid_we=%h mid_addr=%0d, required 13 / 80 / 3",
                   bus.sum, bus.mid_we, bus.mid_addr);
        end
      end
      if (bus.out_valid === 1'b1) begin
        pulses++;
        checks++;
        if (bus.sum !== 16'd4 || bus.out_idx !== 4'(pulses - 1) || cyc != 3000 + 6 * pulses ||
            bus.mid_we !== 64'h0) begin
          fails++;
          $display("FAIL l2_out: cyc=%0d sum=%0d idx=%0d mid_we=%h, required cyc %0d sum 4 idx %0d mid_we 0",
                   cyc, bus.sum, bus.out_idx, bus.mid_we, 3000 + 6 * pulses, pulses - 1);
        end
      end
      tick();
    end
    checks++;
    if (pulses != 10) begin
      fails++;
      $display("FAIL l2_pulses: got %0d out_valid pulses, required 10", pulses);
    end
  endtask

  task automatic test_addressing();
    bus.psum = 16'sd0;
    start_pulse();
    for (int cyc = 1; cyc <= 3058; cyc++) begin
      if (cyc == 76) begin
        checks++;
        if (bus.w_addr !== 12'd65 || bus.in_addr !== 4'd0 || bus.lane_en !== '1 || bus.w_sel !== 1'b0) begin
          fails++;
          $display("FAIL addr_n5c0: w_addr=%0d in_addr=%0d lane_en=%h w_sel=%b, required 65 / 0 / all ones / 0",
                   bus.w_addr, bus.in_addr, bus.lane_en, bus.w_sel);
        end
      end
      if (cyc == 88) begin
        checks++;
        if (bus.w_addr !== 12'd77 || bus.in_addr !== 4'd12 || bus.lane_en !== 64'h000000000000FFFF ||
            bus.w_sel !== 1'b0) begin
          fails++;
          $display("FAIL addr_n5c12: w_addr=%0d in_addr=%0d lane_en=%h w_sel=%b, required 77 / 12 / FFFF / 0",
                   bus.w_addr, bus.in_addr, bus.lane_en, bus.w_sel);
        end
      end
      if (cyc == 89) begin
        checks++;
        if (bus.w_addr !== 12'd0 || bus.in_addr !== 4'd0 || bus.lane_en !== 64'h0 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL addr_drain: w_addr=%0d in_addr=%0d lane_en=%h busy=%b, required 0 / 0 / 0 / 1",
                   bus.w_addr, bus.in_addr, bus.lane_en, bus.busy);
        end
      end
      if (cyc == 3001) begin
        checks++;
        if (bus.w_addr !== 12'd0 || bus.w_sel !== 1'b1 || bus.lane_en !== '1 || bus.mid_addr !== 2'd0) begin
          fails++;
          $display("FAIL addr_l2n0c0: w_addr=%0d w_sel=%b lane_en=%h mid_addr=%0d, required 0 / 1 / all ones / 0",
                   bus.w_addr, bus.w_sel, bus.lane_en, bus.mid_addr);
        end
      end
      if (cyc == 3058) begin
        checks++;
        if (bus.w_addr !== 12'd39 || bus.w_sel !== 1'b1 || bus.lane_en !== 64'h00000000000000FF ||
            bus.mid_addr !== 2'd3) begin
          fails++;
          $display("FAIL addr_l2n9c3: w_addr=%0d w_sel=%b lane_en=%h mid_addr=%0d, required 39 / 1 / FF / 3",
                   bus.w_addr, bus.w_sel, bus.lane_en, bus.mid_addr);
        end
      end
      tick();
    end
    apply_reset();
  endtask

  task automatic test_saturation();
    bus.psum = 16'sh4000;
    start_pulse();
    for (int i = 1; i < 15; i++) tick();
    checks++;
    if (bus.sum !== 16'h7FFF) begin
      fails++;
      $display("FAIL sat_pos: sum=%h, required 7fff", bus.sum);
    end
    apply_reset();
    bus.psum = 16'shC000;
    start_pulse();
    for (int i = 1; i < 15; i++) tick();
    checks++;
    if (bus.sum !== 16'h8000) begin
      fails++;
      $display("FAIL sat_neg: sum=%h, required 8000", bus.sum);
    end
    apply_reset();
    alt_mode = 1'b1;
    bus.psum = 16'sh0000;
    start_pulse();
    for (int i = 1; i < 15; i++) tick();
    checks++;
    if (bus.sum !== 16'h7000 || bus.mid_we !== 64'h1) begin
      fails++;
      $display("FAIL sat_alt: sum=%h mid_we=%h, required 7000 / 1", bus.sum, bus.mid_we);
    end
    alt_mode = 1'b0;
    apply_reset();
  endtask

  task automatic test_timing();
    int done_cnt;
    done_cnt = 0;
    bus.psum = 16'sd1;
    start_pulse();
    for (int cyc = 1; cyc <= 3062; cyc++) begin
      if (cyc == 500) bus.start = 1'b1;
      if (cyc == 501) bus.start = 1'b0;
      if (bus.done === 1'b1) done_cnt++;
      if (cyc == 3060) begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL time_3060: done=%b busy=%b, required 0 / 1", bus.done, bus.busy);
        end
      end
      if (cyc == 3061) begin
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin
          fails++;
          $display("FAIL time_3061: done=%b busy=%b, required 1 / 1", bus.done, bus.busy);
        end
      end
      if (cyc == 3062) begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL time_3062: done=%b busy=%b, required 0 / 0", bus.done, bus.busy);
        end
      end
      if (cyc == 3062) break;
      tick();
    end
    checks++;
    if (done_cnt != 1) begin
      fails++;
      $display("FAIL time_done_count: done high %0d cycles, required 1", done_cnt);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL time_idle_after: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_restart();
    bus.psum = 16'sd1;
    start_pulse();
    for (int cyc = 1; cyc < 755; cyc++) tick();
    #2 rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    start_pulse();
    checks++;
    if (bus.w_addr !== 12'd0 || bus.in_addr !== 4'd0 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_c1: w_addr=%0d in_addr=%0d busy=%b, required 0 / 0 / 1",
               bus.w_addr, bus.in_addr, bus.busy);
    end
    for (int i = 1; i < 15; i++) tick();
    checks++;
    if (bus.mid_we !== 64'h1 || bus.sum !== 16'd13 || bus.mid_addr !== 2'd0) begin
      fails++;
      $display("FAIL restart_wb: mid_we=%h sum=%0d mid_addr=%0d, required 1 / 13 / 0",
               bus.mid_we, bus.sum, bus.mid_addr);
    end
    apply_reset();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.psum  = 16'sd0;
    rst       = 1'b0;
    tick();
    tick();
    test_reset();
    test_accumulate();
    apply_reset();
    test_addressing();
    test_saturation();
    test_timing();
    test_reset_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
